// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   A registered pipeline stage with valid/ready handshakes on both sides.
//   An accepted entry appears at the output one cycle after it is accepted.
//   When the output holds no valid entry, out_data_o carries NOP_VALUE.
//
// Configuration:
//   PIPE_STAGE_SKID_EN (undefined by default)
//     undefined : one entry of storage. in_ready_o is combinational:
//                 ~out_valid_o | out_ready_i.
//     defined   : an output register plus one skid register (EMPTY/BUSY/FULL).
//                 in_ready_o comes straight from a flop, so there is no
//                 combinational path from out_ready_i to in_ready_o.
//
// Parameters:
//   DATA_W     payload width in bits (1..256)
//   NOP_VALUE  payload driven while out_valid_o = 0
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   flush_i      synchronous discard of every held entry (highest priority)
//   in_valid_i   upstream entry present
//   in_ready_o   stage accepts an entry this cycle
//   in_data_i    upstream payload
//   out_valid_o  registered entry presented downstream
//   out_ready_i  downstream accepts the entry
//   out_data_o   registered payload
//   occupancy_o  number of entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned        DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              in_fire;
    logic              out_fire;

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_q & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN

    // The encoding equals the number of held entries, so occupancy_o is the
    // state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] skid_q;

    assign in_ready_o  = in_ready_q;
    assign occupancy_o = state_q;

    // NOTE: every register in this block uses non-blocking assignments so all
    // of them see the pre-edge values of in_fire/out_fire and of each other.
    // NOTE: the payload registers are reset as well, because out_data_o must
    // read NOP_VALUE for as long as rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
        end else if (flush_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= BUSY;
                        out_valid_q <= 1'b1;
                        out_data_q  <= in_data_i;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        // Zero-bubble pass-through.
                        out_data_q <= in_data_i;
                    end else if (in_fire) begin
                        // Output is stalled; park the new entry in the skid.
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                        skid_q     <= in_data_i;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                        out_data_q  <= NOP_VALUE;
                    end
                end
                FULL: begin
                    // in_ready_o is low here, so only the output can move.
                    if (out_fire) begin
                        state_q    <= BUSY;
                        in_ready_q <= 1'b1;
                        out_data_q <= skid_q;
                        skid_q     <= NOP_VALUE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_data_q  <= NOP_VALUE;
                    skid_q      <= NOP_VALUE;
                end
            endcase
        end
    end

`else

    // Single entry: accept whenever the output is empty or is leaving now.
    assign in_ready_o  = ~out_valid_q | out_ready_i;
    assign occupancy_o = {1'b0, out_valid_q};

    // NOTE: non-blocking assignments keep out_valid_q/out_data_q consistent
    // with the pre-edge handshake; the payload register is reset so that
    // out_data_o reads NOP_VALUE throughout reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= NOP_VALUE;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= NOP_VALUE;
        end else if (in_fire) begin
            // Covers both load-from-empty and simultaneous in/out transfer.
            out_valid_q <= 1'b1;
            out_data_q  <= in_data_i;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_data_q  <= NOP_VALUE;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg (DATA_W = 32, NOP_VALUE = 0).
// A queue holds the entries the stage should contain; its head is what the
// output must show. Directed scenarios with literal expectations come first,
// followed by randomized traffic with flushes and occasional async resets.
// Works for either build of PIPE_STAGE_SKID_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    localparam int DW = 32;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;

    int vectors     = 0;
    int miscompares = 0;

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: queue of held entries ----------------
    logic [DW-1:0] model_q[$];

    function automatic logic model_in_ready();
        if (CAP == 1) return (model_q.size() == 0) || out_ready_i;
        else          return model_q.size() < CAP;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
        end else if (flush_i) begin
            model_q.delete();
        end else begin
            automatic logic ifire = in_valid_i && model_in_ready();
            automatic logic ofire = (model_q.size() > 0) && out_ready_i;
            if (ofire) void'(model_q.pop_front());
            if (ifire) model_q.push_back(in_data_i);
        end
    end

    // Compare on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        automatic logic          e_valid = model_q.size() > 0;
        automatic logic [DW-1:0] e_data  = e_valid ? model_q[0] : 32'h0;
        check("out_valid", {31'b0, out_valid_o}, {31'b0, e_valid});
        check("out_data", out_data_o, e_data);
        check("occupancy", {30'b0, occupancy_o}, model_q.size());
        check("in_ready", {31'b0, in_ready_o}, {31'b0, model_in_ready()});
    end

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic v, input logic [DW-1:0] d, input int occ);
        check({tag, ".valid"}, {31'b0, out_valid_o}, {31'b0, v});
        check({tag, ".data"}, out_data_o, d);
        check({tag, ".occ"}, {30'b0, occupancy_o}, occ);
    endtask

    initial begin
        // Reset held with an active, ignored upstream entry.
        rst = 1'b0; flush_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit("reset", 1'b0, 32'h0, 0);
        end

        // Release reset and stream 1..4 back to back.
        after_edge();
        rst = 1'b1; in_valid_i = 1'b1; in_data_i = 32'd1;
        for (int i = 1; i <= 4; i++) begin
            after_edge();
            if (i < 4) in_data_i = i + 1;
            else       in_valid_i = 1'b0;
            @(negedge clk);
            lit("stream", 1'b1, i, 1);
        end
        @(negedge clk);
        lit("stream_drain", 1'b0, 32'h0, 0);

        // Backpressure: A then B with the output stalled.
        after_edge();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA;
        after_edge();
        in_data_i = 32'hB;
        @(negedge clk);
        lit("bp_a", 1'b1, 32'hA, 1);
        check("bp_a.in_ready", {31'b0, in_ready_o}, (CAP == 2) ? 32'd1 : 32'd0);
        after_edge();
`ifdef PIPE_STAGE_SKID_EN
        in_valid_i = 1'b0;   // B went into the skid on the last edge
`endif
        @(negedge clk);
        lit("bp_hold", 1'b1, 32'hA, CAP);
        check("bp_hold.in_ready", {31'b0, in_ready_o}, 32'd0);
        out_ready_i = 1'b1;
        after_edge();
        in_valid_i = 1'b0;
        @(negedge clk);
        lit("bp_b", 1'b1, 32'hB, 1);
        @(negedge clk);
        lit("bp_empty", 1'b0, 32'h0, 0);

        // Bubble: one entry, then nothing.
        after_edge();
        in_valid_i = 1'b1; in_data_i = 32'h5; out_ready_i = 1'b1;
        after_edge();
        in_valid_i = 1'b0;
        @(negedge clk);
        lit("bubble_5", 1'b1, 32'h5, 1);
        @(negedge clk);
        lit("bubble_nop", 1'b0, 32'h0, 0);

        // Flush priority over a same-cycle push of 7.
        after_edge();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'd11;
        after_edge();
        in_data_i = 32'd12;
        after_edge();
        flush_i = 1'b1; in_data_i = 32'h7;
        @(negedge clk);
        lit("pre_flush", 1'b1, 32'd11, CAP);
        after_edge();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk);
        lit("flushed", 1'b0, 32'h0, 0);
        @(negedge clk);
        lit("flushed_no7", 1'b0, 32'h0, 0);

        // Async reset between edges with the stage as full as it gets.
        after_edge();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'd21;
        after_edge();
        in_data_i = 32'd22;
        after_edge();
        in_valid_i = 1'b0;
        #1;
        check("pre_async.occ", {30'b0, occupancy_o}, CAP);
        rst = 1'b0;
        #1;
        lit("async_rst", 1'b0, 32'h0, 0);
        after_edge();
        rst = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            after_edge();
            in_valid_i  = ($urandom_range(3) != 0);
            in_data_i   = $urandom;
            out_ready_i = ($urandom_range(2) != 0);
            flush_i     = ($urandom_range(39) == 0);
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        after_edge();
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
